// File: rtl/adder_bit_serial_seq_if.sv
// Operand/result handshake bundle for the bit-serial adder sequencer.
// The slave modport is the sequencer side; the master modport is the requester/consumer side.
interface adder_bit_serial_seq_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_num_a;
  logic [DATA_WIDTH-1:0] i_num_b;
  logic                  i_cry;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_res;
  logic                  o_cry;
  logic                  o_busy;

  modport slave (
    input  i_valid, i_num_a, i_num_b, i_cry, i_ready,
    output o_ready, o_valid, o_res, o_cry, o_busy
  );

  modport master (
    output i_valid, i_num_a, i_num_b, i_cry, i_ready,
    input  o_ready, o_valid, o_res, o_cry, o_busy
  );
endinterface

// File: rtl/adder_bit_serial_seq.sv
// Bit-serial adder: one full-adder cell consumes the operands LSB-first, one bit per clock,
// while the sum bits are shifted in from the MSB side of the result register.
module adder_bit_serial_seq #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  adder_bit_serial_seq_if.slave     bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic                  cry_q, cry_d, sum_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, valid_q, busy_q;

  always_comb begin
    sum_d = a_q[0] ^ b_q[0] ^ cry_q;
    cry_d = (a_q[0] & b_q[0]) | (a_q[0] & cry_q) | (b_q[0] & cry_q);
    res_d = res_q >> 1;
    res_d[DATA_WIDTH-1] = sum_d;
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Status outputs are registered next to the state so they never see i_valid/i_ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cry_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            a_q     <= bus.i_num_a;
            b_q     <= bus.i_num_b;
            cry_q   <= bus.i_cry;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          cry_q <= cry_d;
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_res   = res_q;
  assign bus.o_cry   = cry_q;

endmodule
